// File: rtl/video_matrix_fetch.sv
// video_matrix_fetch: c-access/g-access address generation, VC/VCBASE/RC/VMLI
// bookkeeping and the video matrix line buffer feeding the pixel sequencer.
//
// Ports:
//   rst                  synchronous active-high reset
//   clk_dot4x            system clock (4x dot clock)
//   clk_phi              phase level: 0 = PHI1 (g-access), 1 = PHI2 (c-access)
//   phi_phase_start_dav  one-tick bus-data-valid strobe inside each phase
//   cycle_num            current raster cycle
//   badline              badline condition for the current cycle
//   ecm, bmm             extended colour mode, bitmap mode
//   vm, cb               video matrix base (addr 13:10), char/bitmap base (addr 13:11)
//   dbus                 fetched data: [11:8] colour RAM, [7:0] DRAM
//   vic_addr             fetch address for the current phase (registered)
//   char_read            {colour, screen byte} of the current g-access
//   pixels_read          g-access pixel byte
//   idle                 1 = idle state, 0 = display state
//   vc, rc               video counter, row counter
//
// Optional build macro BA_STALL_DATA_EN: for three cycles after a badline
// rising edge past cycle 11, c-accesses store {colour, 8'hFF} because the
// CPU still owns the bus.
module video_matrix_fetch #(
    parameter int LINEBUF_DEPTH = 40,
    parameter int FIRST_C_CYCLE = 15
) (
    input  logic        rst,
    input  logic        clk_dot4x,
    input  logic        clk_phi,
    input  logic        phi_phase_start_dav,
    input  logic [6:0]  cycle_num,
    input  logic        badline,
    input  logic        ecm,
    input  logic        bmm,
    input  logic [3:0]  vm,
    input  logic [2:0]  cb,
    input  logic [11:0] dbus,
    output logic [13:0] vic_addr,
    output logic [11:0] char_read,
    output logic [7:0]  pixels_read,
    output logic        idle,
    output logic [9:0]  vc,
    output logic [2:0]  rc
);
    localparam int VW = $clog2(LINEBUF_DEPTH);
    localparam logic [6:0] C_LOAD = 7'(FIRST_C_CYCLE - 1);
    localparam logic [6:0] C_FIRST = 7'(FIRST_C_CYCLE);
    localparam logic [6:0] C_LAST = 7'(FIRST_C_CYCLE + LINEBUF_DEPTH - 1);
    localparam logic [6:0] G_FIRST = 7'(FIRST_C_CYCLE + 1);
    localparam logic [6:0] G_LAST = 7'(FIRST_C_CYCLE + LINEBUF_DEPTH);
    localparam logic [6:0] C_ROWEND = 7'd58;
    localparam logic [VW-1:0] VMLI_MAX = VW'(LINEBUF_DEPTH - 1);

    logic [11:0] linebuf [LINEBUF_DEPTH];
    logic [9:0] vc_q, vc_d, vcbase_q, vcbase_d;
    logic [2:0] rc_q, rc_d;
    logic [VW-1:0] vmli_q, vmli_d;
    logic idle_q, idle_d, abort_q;
    logic [11:0] char_q, char_d, lb_rd, c_data;
    logic [7:0] pix_q, pix_d;
    logic [13:0] addr_q, addr_d, g_addr;
    logic dav1, dav2, bl, c_win, g_win, disp;

    assign dav1 = phi_phase_start_dav & ~clk_phi;
    assign dav2 = phi_phase_start_dav & clk_phi;
    // A mid-line reset blanks badline until the next line begins.
    assign bl = badline & ~abort_q;
    assign c_win = (cycle_num >= C_FIRST) && (cycle_num <= C_LAST);
    assign g_win = (cycle_num >= G_FIRST) && (cycle_num <= G_LAST);
    assign disp = g_win & ~idle_q;
    assign lb_rd = linebuf[vmli_q];

`ifdef BA_STALL_DATA_EN
    logic [1:0] stall_q;
    logic bl_prev_q, bl_rise;
    assign bl_rise = bl & ~bl_prev_q & (cycle_num > 7'd11);
    // The rising-edge cycle itself is the first stalled cycle, so two more follow.
    assign c_data = (bl_rise | (stall_q != 2'd0)) ? {dbus[11:8], 8'hFF} : dbus;
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            stall_q <= 2'd0;
            bl_prev_q <= 1'b0;
        end else if (dav2) begin
            stall_q <= bl_rise ? 2'd2 : (stall_q != 2'd0) ? stall_q - 2'd1 : 2'd0;
            bl_prev_q <= bl;
        end
    end
`else
    assign c_data = dbus;
`endif

    always_comb begin
        g_addr = idle_q ? 14'h3FFF : bmm ? {cb[2], vc_q, rc_q} : {cb, lb_rd[7:0], rc_q};
        if (ecm) g_addr[10:9] = 2'b00;
        addr_d = clk_phi ? {vm, vc_q} : g_win ? g_addr : 14'h3FFF;
    end

    always_comb begin
        vc_d = vc_q;
        vcbase_d = vcbase_q;
        rc_d = rc_q;
        vmli_d = vmli_q;
        idle_d = idle_q;
        char_d = char_q;
        pix_d = pix_q;
        if (dav1) begin
            char_d = disp ? lb_rd : 12'h000;
            pix_d = g_win ? dbus[7:0] : 8'h00;
            vc_d = disp ? vc_q + 10'd1 : vc_q;
            vmli_d = (disp && vmli_q != VMLI_MAX) ? vmli_q + 1'b1 : vmli_q;
        end
        if (dav2) begin
            if (cycle_num == C_LOAD) begin
                vc_d = vcbase_q;
                vmli_d = '0;
                if (bl) rc_d = 3'd0;
            end
            if (cycle_num == C_ROWEND) begin
                if (rc_q == 3'd7) begin
                    vcbase_d = vc_q;
                    idle_d = 1'b1;
                end else if (!idle_q) begin
                    rc_d = rc_q + 3'd1;
                end
            end
            // Badline overrides the end-of-row return to idle.
            if (bl) idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            vc_q <= '0;
            vcbase_q <= '0;
            rc_q <= '0;
            vmli_q <= '0;
            idle_q <= 1'b1;
            char_q <= '0;
            pix_q <= '0;
            addr_q <= 14'h3FFF;
            abort_q <= 1'b1;
        end else begin
            vc_q <= vc_d;
            vcbase_q <= vcbase_d;
            rc_q <= rc_d;
            vmli_q <= vmli_d;
            idle_q <= idle_d;
            char_q <= char_d;
            pix_q <= pix_d;
            addr_q <= addr_d;
            abort_q <= abort_q & ~(phi_phase_start_dav & (cycle_num < C_LOAD));
        end
    end

    // Line buffer is deliberately not reset; stale entries are architectural.
    always_ff @(posedge clk_dot4x) begin
        if (!rst && dav2 && bl && c_win) linebuf[vmli_q] <= c_data;
    end

    assign vic_addr = addr_q;
    assign char_read = char_q;
    assign pixels_read = pix_q;
    assign idle = idle_q;
    assign vc = vc_q;
    assign rc = rc_q;
endmodule

// File: tb/tb_video_matrix_fetch.sv
// tb_video_matrix_fetch: randomized line-by-line stimulus with a reference model and scoreboard
module tb_video_matrix_fetch;
    logic rst = 1'b1;
    logic clk_dot4x = 1'b0;
    logic clk_phi = 1'b0;
    logic dav = 1'b0;
    logic badline = 1'b0;
    logic ecm = 1'b0;
    logic bmm = 1'b0;
    logic [6:0] cycle_num = '0;
    logic [3:0] vm = '0;
    logic [2:0] cb = '0;
    logic [11:0] dbus = '0;
    logic [13:0] vic_addr;
    logic [11:0] char_read;
    logic [7:0] pixels_read;
    logic idle;
    logic [9:0] vc;
    logic [2:0] rc;

    video_matrix_fetch dut (
        .rst(rst), .clk_dot4x(clk_dot4x), .clk_phi(clk_phi), .phi_phase_start_dav(dav),
        .cycle_num(cycle_num), .badline(badline), .ecm(ecm), .bmm(bmm), .vm(vm), .cb(cb),
        .dbus(dbus), .vic_addr(vic_addr), .char_read(char_read), .pixels_read(pixels_read),
        .idle(idle), .vc(vc), .rc(rc)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    typedef struct {
        int addr; int ch; int pix; int idl; int vcv; int rcv; int line; int cyc; int phi;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cur_line = 0;

    int m_vc = 0, m_vcbase = 0, m_rc = 0, m_vmli = 0, m_idle = 1, m_abort = 1;
    int m_ch = 0, m_pix = 0, m_stall = 0, m_prev_bl = 0;
    int m_lb [40];

    function automatic int model_addr(input int phi, input int cyc);
        int a;
        if (phi != 0) return int'(vm) * 1024 + m_vc;
        if (cyc < 16 || cyc > 55) return 'h3FFF;
        if (m_idle != 0) a = 'h3FFF;
        else if (bmm) a = (int'(cb) / 4) * 8192 + m_vc * 8 + m_rc;
        else a = int'(cb) * 2048 + (m_lb[m_vmli] % 256) * 8 + m_rc;
        return ecm ? (a & 'h39FF) : a;
    endfunction

    task automatic step_model(input int phi, input int cyc, input int bl_raw, input int d, input int do_rst);
        exp_t e;
        int bl;
        e.addr = rst ? 'h3FFF : model_addr(phi, cyc);
        if (do_rst != 0) begin
            m_vc = 0; m_vcbase = 0; m_rc = 0; m_vmli = 0; m_idle = 1; m_abort = 1;
            m_ch = 0; m_pix = 0; m_stall = 0; m_prev_bl = 0;
        end else begin
            bl = (bl_raw != 0 && m_abort == 0) ? 1 : 0;
            if (cyc < 14) m_abort = 0;
            if (phi == 0) begin
                if (cyc >= 16 && cyc <= 55) begin
                    m_pix = d % 256;
                    m_ch = m_idle ? 0 : m_lb[m_vmli];
                    if (m_idle == 0) begin
                        m_vc = (m_vc + 1) % 1024;
                        m_vmli = (m_vmli < 39) ? m_vmli + 1 : 39;
                    end
                end else begin
                    m_pix = 0;
                    m_ch = 0;
                end
            end else begin
`ifdef BA_STALL_DATA_EN
                if (bl != 0 && m_prev_bl == 0 && cyc > 11) m_stall = 3;
`endif
                if (bl != 0 && cyc >= 15 && cyc <= 54) m_lb[m_vmli] = (m_stall > 0) ? ((d & 'hF00) | 'hFF) : d;
                if (m_stall > 0) m_stall--;
                m_prev_bl = bl;
                if (cyc == 14) begin
                    m_vc = m_vcbase;
                    m_vmli = 0;
                    if (bl != 0) m_rc = 0;
                end
                if (cyc == 58) begin
                    if (m_rc == 7) begin
                        m_vcbase = m_vc;
                        m_idle = 1;
                    end else if (m_idle == 0) begin
                        m_rc = (m_rc + 1) % 8;
                    end
                end
                if (bl != 0) m_idle = 0;
            end
        end
        e.ch = m_ch; e.pix = m_pix; e.idl = m_idle; e.vcv = m_vc; e.rcv = m_rc;
        e.line = cur_line; e.cyc = cyc; e.phi = phi;
        sb.push_back(e);
    endtask

    task automatic do_phase(input int phi, input int cyc, input int bl, input int d, input int do_rst);
        clk_phi = 1'(phi);
        cycle_num = 7'(cyc);
        badline = 1'(bl);
        @(posedge clk_dot4x); #1;
        dbus = 12'(d);
        dav = 1'b1;
        step_model(phi, cyc, bl, d, do_rst);
        rst = 1'(do_rst);
        @(posedge clk_dot4x); #1;
        dav = 1'b0;
        rst = 1'b0;
        @(posedge clk_dot4x); #1;
    endtask

    task automatic run_line(input int bs, input int ra, input int fill);
        int d;
        for (int c = 0; c < 63; c++) begin
            for (int p = 0; p < 2; p++) begin
                d = int'($urandom & 32'hFFF);
                if (fill != 0 && p == 1) d = (d & 'hF00) | c;
                do_phase(p, c, (bs >= 0 && c >= bs) ? 1 : 0, d, (p == 1 && c == ra) ? 1 : 0);
            end
        end
    endtask

    task automatic chk(input string nm, input exp_t e, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s line %0d cycle %0d phi %0d: got %0h want %0h", nm, e.line, e.cyc, e.phi, act, want);
        end
    endtask

    initial forever begin
        @(negedge clk_dot4x);
        if (dav) begin
            logic [13:0] a;
            exp_t e;
            a = vic_addr;
            @(negedge clk_dot4x);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got an output with no expectation queued");
            end else begin
                e = sb.pop_front();
                chk("vic_addr", e, 16'(a), 16'(e.addr));
                chk("char_read", e, 16'(char_read), 16'(e.ch));
                chk("pixels_read", e, 16'(pixels_read), 16'(e.pix));
                chk("idle", e, 16'(idle), 16'(e.idl));
                chk("vc", e, 16'(vc), 16'(e.vcv));
                chk("rc", e, 16'(rc), 16'(e.rcv));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int bs, ra;
        repeat (3) @(posedge clk_dot4x);
        #1;
        do_phase(0, 0, 0, int'($urandom & 32'hFFF), 1);
        for (int ln = 0; ln < 30; ln++) begin
            cur_line = ln;
            bs = -1;
            ra = -1;
            vm = 4'($urandom);
            cb = 3'($urandom);
            ecm = 1'($urandom);
            bmm = 1'($urandom);
            if (ln == 0) begin
                bs = 14; vm = 4'h1; ecm = 1'b0; bmm = 1'b0;
            end else if (ln == 8) begin
                ecm = 1'b1;
            end else if (ln == 9) begin
                bs = 30;
            end else if (ln == 10) begin
                bs = 14; ra = 35;
            end else if (ln == 11) begin
                bs = 14;
            end else if (ln == 14) begin
                cb = 3'b010; ecm = 1'b0; bmm = 1'b0;
            end else if (ln == 18) begin
                bs = 40;
            end else if (ln >= 19) begin
                bs = ($urandom_range(0, 2) == 0) ? -1 : ($urandom_range(0, 1) != 0) ? 14 : int'($urandom_range(15, 60));
            end
            run_line(bs, ra, (ln == 0) ? 1 : 0);
        end
        repeat (4) @(posedge clk_dot4x);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
